cla_seq_controller: RTL and testbench
=====================================

Name: cla_seq_controller

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands through one CHUNK-bit carry-lookahead slice.
- The slice is built from per-bit propagate/generate cells: p = a^b, g = a&b.
- Each cycle the sequencer processes one CHUNK-bit slice, LSB slice first, and keeps the inter-slice carry in a register.
- Sits between a requester (start/done handshake) and the arithmetic datapath; trades latency for area when wide adds are infrequent.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per cycle by the lookahead slice; 1 <= CHUNK <= WIDTH.
(Derived: NSLICE = WIDTH/CHUNK; counter width = clog2(NSLICE), minimum 1.)

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request pulse; sampled only when ready=1.
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry-in to slice 0; captured on accepted start.
ready  output  1  high in IDLE and DONE; start is accepted only when high.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse in DONE; sum/cout/ovf valid.
sum  output  WIDTH  result; holds its value until the next accepted start.
cout  output  1  carry out of the MSB.
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, slice counter=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, done=0, busy=0, ready=1. Reset overrides start.
- Reset mid-RUN aborts the operation. No done pulse is produced; the partial sum is discarded and reads 0.
- FSM states:
  - IDLE: start=1 → latch a, b, cin; clear sum; counter=0; go to RUN. start=0 → stay.
  - RUN: each cycle computes slice k = counter.
    - Bits [k*CHUNK +: CHUNK] use the carry reg as c0.
    - Internal carries are flattened lookahead: c(i+1) = g(i) | p(i)&g(i-1) | ... | p(i..0)&c0. No ripple chain between bit cells.
    - Slice sum = p ^ c, written into sum[k*CHUNK +: CHUNK]; carry reg <= slice carry-out; counter++.
    - When counter = NSLICE-1: latch cout = slice carry-out and ovf = (carry into MSB) ^ cout; go to DONE.
  - DONE: done=1 for exactly this one cycle.
    - start=1 → accept the new operands (back-to-back) and go to RUN.
    - Otherwise go to IDLE.
- start while busy=1 is ignored: no queuing, no effect on the in-flight operation.
- Operands are registered at accept, so a/b/cin may change freely during RUN.
- Latency: start accepted at edge E0 → RUN occupies cycles 1..NSLICE → done high in cycle NSLICE+1 (9 cycles for defaults).
- Throughput: one add per NSLICE+1 cycles when start is held high continuously.
- sum, cout and ovf are registered outputs, stable from DONE until the next accepted start. Upper slices read 0 during RUN.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB appears only on cout.
- NSLICE=1 (CHUNK=WIDTH) is legal: one RUN cycle, then DONE.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, start=0 → ready=1, busy=0, done=0, sum=0, cout=0 indefinitely.
- Basic add (defaults): a=0x0000_1234, b=0x0000_4321, cin=0, start pulse → busy for 8 cycles, done in cycle 9, sum=0x0000_5555, cout=0, ovf=0.
- Full carry propagation: a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0. Also a=0x7FFF_FFFF, b=1, cin=0 → sum=0x8000_0000, cout=0, ovf=1.
- Ignored start: a=5, b=6 accepted; mid-RUN start=1 with a=b=0xFFFF_FFFF → single done with sum=11; no second operation starts.
- Back-to-back: start held high with (1+2), then (0x8000_0000+0x8000_0000) presented in the DONE cycle → done pulses 9 cycles apart; sums 3 and 0, second cout=1, ovf=1.
- Reset mid-operation: rst_n=0 during RUN cycle 4 → next cycle IDLE, sum=0, no done pulse. A subsequent 2+3 completes normally with sum=5.

Source files
------------

// File: rtl/cla_seq_controller.sv
// Multi-cycle adder sequencer: one CHUNK-bit carry-lookahead slice per cycle,
// LSB slice first, with the inter-slice carry held in a register.
module cla_seq_controller #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, ovf_q;
    logic             ready_q, busy_q, done_q;

    logic [CHUNK-1:0] slice_a, slice_b, slice_p, slice_g, slice_sum_d;
    logic [CHUNK:0]   slice_c;
    logic             slice_cout_d, slice_cmsb_d;
    int               base;

    // Flattened lookahead: every carry is a sum of products of p/g and c0,
    // so no carry depends on a neighbouring carry.
    function automatic logic [CHUNK:0] lookahead(input logic [CHUNK-1:0] p,
                                                 input logic [CHUNK-1:0] g,
                                                 input logic             c0);
        logic [CHUNK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < CHUNK; i++) begin
            term = c0;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    always_comb begin
        base         = int'(cnt_q) * CHUNK;
        slice_a      = a_q[base +: CHUNK];
        slice_b      = b_q[base +: CHUNK];
        slice_p      = slice_a ^ slice_b;
        slice_g      = slice_a & slice_b;
        slice_c      = lookahead(slice_p, slice_g, carry_q);
        slice_sum_d  = slice_p ^ slice_c[CHUNK-1:0];
        slice_cout_d = slice_c[CHUNK];
        slice_cmsb_d = slice_c[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if ((state_q == IDLE || state_q == FIN) && start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    sum_q[base +: CHUNK] <= slice_sum_d;
                    carry_q <= slice_cout_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cout_q  <= slice_cout_d;
                        ovf_q   <= slice_cmsb_d ^ slice_cout_d;
                        state_q <= FIN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_cla_seq_controller.sv
// Directed bench for cla_seq_controller at default parameters (32-bit, 4-bit slices).
module tb_cla_seq_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        cin;
    logic        ready, busy, done, cout, ovf;
    logic [31:0] sum;

    int errors = 0;
    int checks = 0;

    cla_seq_controller #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns cycles until done (0 on timeout).
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          output int cyc, output int busyc);
        int n;
        a = av; b = bv; cin = ci; start = 1'b1;
        cyc = 0; busyc = 0; n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0; a = '1; b = '1; cin = 1'b1;
            end
            if (busy) busyc++;
            if (done) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
            checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
            checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        end
    endtask

    task automatic test_basic_add();
        int cyc, busyc;
        run_op(32'h0000_1234, 32'h0000_4321, 1'b0, cyc, busyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", cyc); end
        checks++; if (busyc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", busyc); end
        checks++; if (sum !== 32'h0000_5555) begin errors++; $display("FAIL basic_sum: got %h expected 00005555", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_in_done: got %b expected 1", ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (sum !== 32'h0000_5555) begin errors++; $display("FAIL basic_sum_hold: got %h expected 00005555", sum); end
    endtask

    task automatic test_full_carry();
        int cyc, busyc;
        run_op(32'hFFFF_FFFF, 32'h0, 1'b1, cyc, busyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL carry1_latency: got %0d expected 9", cyc); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL carry1_sum: got %h expected 0", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry1_cout: got %b expected 1", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL carry1_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, cyc, busyc);
        checks++; if (sum !== 32'h8000_0000) begin errors++; $display("FAIL carry2_sum: got %h expected 80000000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL carry2_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL carry2_ovf: got %b expected 1", ovf); end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int n, ndone, first;
        a = 32'd5; b = 32'd6; cin = 1'b0; start = 1'b1;
        n = 0; ndone = 0; first = 0;
        while (n < 25) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (n == 3) begin start = 1'b1; a = '1; b = '1; end
            if (n == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = n;
                    checks++; if (sum !== 32'd11) begin errors++; $display("FAIL ignored_sum: got %0d expected 11", sum); end
                end
            end
        end
        checks++; if (first !== 9) begin errors++; $display("FAIL ignored_latency: got %0d expected 9", first); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignored_done_count: got %0d expected 1", ndone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n, d1, d2;
        a = 32'd1; b = 32'd2; cin = 1'b0; start = 1'b1;
        n = 0; d1 = 0; d2 = 0;
        while (n < 40 && d2 == 0) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (d1 == 0) begin
                    d1 = n;
                    checks++; if (sum !== 32'd3) begin errors++; $display("FAIL b2b_sum1: got %h expected 3", sum); end
                    a = 32'h8000_0000; b = 32'h8000_0000;
                end else begin
                    d2 = n;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++; if (d1 !== 9) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 9", d1); end
        checks++; if (d2 - d1 !== 9) begin errors++; $display("FAIL b2b_spacing: got %0d expected 9", d2 - d1); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL b2b_sum2: got %h expected 0", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_cout2: got %b expected 1", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf2: got %b expected 1", ovf); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int ndone, cyc, busyc;
        a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL midrst_sum: got %h expected 0", sum); end
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
        run_op(32'd2, 32'd3, 1'b0, cyc, busyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL midrst_after_latency: got %0d expected 9", cyc); end
        checks++; if (sum !== 32'd5) begin errors++; $display("FAIL midrst_after_sum: got %h expected 5", sum); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_full_carry();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
